// File: rtl/stopwatch_display_ctrl.sv
// rtl/stopwatch_display_ctrl.sv - BCD stopwatch/countdown timer with 4-digit multiplexed 7-segment driver
module stopwatch_display_ctrl #(
  parameter int TICK_DIV       = 1000000,
  parameter int SCAN_DIV       = 1000,
  parameter int MAX_MINUTES    = 99,
  parameter int PRESET_MIN     = 1,
  parameter int PRESET_SEC     = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start_stop,
  input  logic        io_lap,
  input  logic        io_clear,
  input  logic        io_dir,
  input  logic        io_view,
  output logic [7:0]  io_seg,
  output logic [3:0]  io_bit,
  output logic        io_running,
  output logic        io_expired,
  output logic [23:0] io_time_bcd
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);
  localparam logic [3:0] PRE_MT = 4'(PRESET_MIN / 10);
  localparam logic [3:0] PRE_MO = 4'(PRESET_MIN % 10);
  localparam logic [3:0] PRE_ST = 4'(PRESET_SEC / 10);
  localparam logic [3:0] PRE_SO = 4'(PRESET_SEC % 10);

  localparam logic [23:0] MAX_BCD    = {MAX_MT, MAX_MO, 8'h59, 8'h99};
  localparam logic [23:0] PRESET_BCD = {PRE_MT, PRE_MO, PRE_ST, PRE_SO, 8'h00};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        cur_q, cur_d;
  logic [23:0]        lap_q, lap_d;
  logic               hold_q, hold_d;
  logic               dir_q, dir_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SCAN_W-1:0]  scan_q;
  logic [3:0]         digit_q;

  logic [23:0]        idle_load;
  logic [23:0]        inc_bcd;
  logic [23:0]        dec_bcd;

  // Digit order LSB first: Co, Ct, So, St, Mo, Mt; only seconds-tens rolls at 5.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == ((i == 3) ? 4'd5 : 4'd9)) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [23:0] r;
    logic        borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = (i == 3) ? 4'd5 : 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  assign idle_load = io_dir ? 24'h000000 : PRESET_BCD;
  assign inc_bcd   = bcd_inc(cur_q);
  assign dec_bcd   = bcd_dec(cur_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      lap_q   <= '0;
      hold_q  <= 1'b0;
      dir_q   <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lap_q   <= lap_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
    end
  end

  // Exactly one event acts per cycle: clear, then start/stop, then lap, then tick.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lap_d   = lap_q;
    hold_d  = hold_q;
    dir_d   = dir_q;
    tick_d  = tick_q;

    if (state_q == IDLE) begin
      cur_d = idle_load;
    end

    if (io_clear) begin
      state_d = IDLE;
      cur_d   = idle_load;
      tick_d  = '0;
      hold_d  = 1'b0;
    end else if (io_start_stop) begin
      case (state_q)
        IDLE: begin
          dir_d = io_dir;
          if (!io_dir && (idle_load == 24'h000000)) begin
            state_d = EXPIRED;
          end else begin
            state_d = RUNNING;
          end
        end
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end else if (io_lap && ((state_q == RUNNING) || (state_q == PAUSED))) begin
      if (hold_q) begin
        hold_d = 1'b0;
      end else begin
        lap_d  = cur_q;
        hold_d = 1'b1;
      end
    end else if (state_q == RUNNING) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (dir_q) begin
          if (cur_q == MAX_BCD) begin
            state_d = EXPIRED;
          end else begin
            cur_d = inc_bcd;
          end
        end else begin
          cur_d = dec_bcd;
          if (dec_bcd == 24'h000000) begin
            state_d = EXPIRED;
          end
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_q  <= '0;
      digit_q <= 4'hE;
    end else if (scan_q == SCAN_LAST) begin
      scan_q  <= '0;
      digit_q <= {digit_q[2:0], digit_q[3]};
    end else begin
      scan_q  <= scan_q + 1'b1;
    end
  end

  logic [23:0] disp_src;
  logic [3:0]  digit_val;
  logic        digit_dp;
  logic        digit_blank;
  logic [7:0]  seg_raw;

  assign disp_src = hold_q ? lap_q : cur_q;

  always_comb begin
    digit_val   = 4'd0;
    digit_dp    = 1'b0;
    digit_blank = 1'b0;
    case (digit_q)
      4'b1110: digit_val = io_view ? disp_src[3:0]   : disp_src[11:8];
      4'b1101: digit_val = io_view ? disp_src[7:4]   : disp_src[15:12];
      4'b1011: begin
        digit_val = io_view ? disp_src[11:8] : disp_src[19:16];
        digit_dp  = 1'b1;
      end
      4'b0111: begin
        digit_val   = io_view ? disp_src[15:12] : disp_src[23:20];
        digit_blank = (digit_val == 4'd0);
      end
      default: digit_blank = 1'b1;
    endcase
    seg_raw = digit_blank ? 8'h00 : {digit_dp, seg_code(digit_val)};
    io_seg  = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  end

  assign io_bit      = digit_q;
  assign io_running  = (state_q == RUNNING);
  assign io_expired  = (state_q == EXPIRED);
  assign io_time_bcd = cur_q;

endmodule

// File: tb/tb_stopwatch_display_ctrl.sv
// tb/tb_stopwatch_display_ctrl.sv - directed checks of stopwatch_display_ctrl on two parameter sets
module tb_stopwatch_display_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start_stop;
  logic        io_lap;
  logic        io_clear;
  logic        io_dir;
  logic        io_view;

  logic [7:0]  a_seg, b_seg;
  logic [3:0]  a_bit, b_bit;
  logic        a_running, b_running;
  logic        a_expired, b_expired;
  logic [23:0] a_time, b_time;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  // A: 99-minute ceiling, 1:00 preset, active-high segments.
  stopwatch_display_ctrl #(
    .TICK_DIV(4), .SCAN_DIV(2), .MAX_MINUTES(99),
    .PRESET_MIN(1), .PRESET_SEC(0), .SEG_ACTIVE_LOW(0)
  ) u_dut_a (
    .clock(clock), .reset(reset), .io_start_stop(io_start_stop), .io_lap(io_lap),
    .io_clear(io_clear), .io_dir(io_dir), .io_view(io_view), .io_seg(a_seg),
    .io_bit(a_bit), .io_running(a_running), .io_expired(a_expired), .io_time_bcd(a_time)
  );

  // B: 1-minute ceiling, 0:01 preset, active-low segments.
  stopwatch_display_ctrl #(
    .TICK_DIV(4), .SCAN_DIV(2), .MAX_MINUTES(1),
    .PRESET_MIN(0), .PRESET_SEC(1), .SEG_ACTIVE_LOW(1)
  ) u_dut_b (
    .clock(clock), .reset(reset), .io_start_stop(io_start_stop), .io_lap(io_lap),
    .io_clear(io_clear), .io_dir(io_dir), .io_view(io_view), .io_seg(b_seg),
    .io_bit(b_bit), .io_running(b_running), .io_expired(b_expired), .io_time_bcd(b_time)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    io_start_stop = 1'b1;
    step(1);
    io_start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    io_lap = 1'b1;
    step(1);
    io_lap = 1'b0;
  endtask

  task automatic pulse_clear();
    io_clear = 1'b1;
    step(1);
    io_clear = 1'b0;
  endtask

  task automatic wait_digit(input logic [3:0] sel);
    int guard = 0;
    while (a_bit != sel && guard < 16) begin
      step(1);
      guard++;
    end
    if (guard >= 16) check("digit_timeout", 32'(a_bit), 32'(sel));
  endtask

  initial begin
    reset         = 1'b1;
    io_start_stop = 1'b0;
    io_lap        = 1'b0;
    io_clear      = 1'b0;
    io_dir        = 1'b1;
    io_view       = 1'b0;
    step(2);
    check("rst_time", 32'(a_time), 'h0);
    check("rst_bit", 32'(a_bit), 'hE);
    check("rst_running", 32'(a_running), 'h0);
    check("rst_expired", 32'(a_expired), 'h0);
    reset = 1'b0;

    // Scan rotation at SCAN_DIV=2 with time 0 in view 0
    step(1);
    check("scan_e0", 32'(a_bit), 'hE);
    step(1);
    check("scan_d", 32'(a_bit), 'hD);
    step(2);
    check("scan_b", 32'(a_bit), 'hB);
    check("seg_d2_dp", 32'(a_seg), 'hBF);
    step(2);
    check("scan_7", 32'(a_bit), 'h7);
    check("seg_d3_blank", 32'(a_seg), 'h00);
    check("seg_d3_blank_lo", 32'(b_seg), 'hFF);
    step(2);
    check("scan_e1", 32'(a_bit), 'hE);
    check("seg_d0_lo", 32'(b_seg), 'hC0);
    check("seg_d0", 32'(a_seg), 'h3F);

    // Up count: 100 ticks in 400 clocks
    pulse_start();
    step(400);
    check("up_1s", 32'(a_time), 'h000100);
    check("up_running", 32'(a_running), 'h1);
    check("up_1s_b", 32'(b_time), 'h000100);

    // Carry into minutes, then B hits its 1-minute ceiling
    step(5899 * 4);
    check("up_5999", 32'(a_time), 'h005999);
    step(4);
    check("up_carry_min", 32'(a_time), 'h010000);
    check("up_carry_min_b", 32'(b_time), 'h010000);
    step(5999 * 4);
    check("b_at_max", 32'(b_time), 'h015999);
    check("b_not_expired", 32'(b_expired), 'h0);
    step(4);
    check("b_max_held", 32'(b_time), 'h015999);
    check("b_max_expired", 32'(b_expired), 'h1);
    check("b_max_running", 32'(b_running), 'h0);
    check("a_past_b_max", 32'(a_time), 'h020000);

    pulse_clear();
    check("clr_time", 32'(a_time), 'h0);
    check("clr_running", 32'(a_running), 'h0);
    check("clr_b_expired", 32'(b_expired), 'h0);

    // Clear beats start; tick counter restarts from 0; pause holds it
    pulse_start();
    step(6);
    io_clear      = 1'b1;
    io_start_stop = 1'b1;
    step(1);
    io_clear      = 1'b0;
    io_start_stop = 1'b0;
    check("clr_start_time", 32'(a_time), 'h0);
    check("clr_start_running", 32'(a_running), 'h0);
    pulse_start();
    step(2);
    check("tick_restart", 32'(a_time), 'h0);
    pulse_start();
    step(10);
    check("paused_time", 32'(a_time), 'h0);
    check("paused_running", 32'(a_running), 'h0);
    pulse_start();
    step(1);
    check("resume_early", 32'(a_time), 'h0);
    step(1);
    check("resume_tick", 32'(a_time), 'h000001);

    // Countdown: B from 0:01.00 to expiry, A from 1:00.00
    io_dir = 1'b0;
    pulse_clear();
    step(1);
    check("idle_preset_b", 32'(b_time), 'h000100);
    check("idle_preset_a", 32'(a_time), 'h010000);
    pulse_start();
    step(396);
    check("dn_b_001", 32'(b_time), 'h000001);
    check("dn_b_not_exp", 32'(b_expired), 'h0);
    step(4);
    check("dn_b_zero", 32'(b_time), 'h0);
    check("dn_b_expired", 32'(b_expired), 'h1);
    check("dn_b_running", 32'(b_running), 'h0);
    check("dn_a_borrow", 32'(a_time), 'h005900);
    pulse_start();
    check("exp_ignores_start", 32'(b_expired), 'h1);
    check("dn_a_paused", 32'(a_running), 'h0);

    // Lap hold in view 1
    io_dir  = 1'b1;
    io_view = 1'b1;
    pulse_clear();
    pulse_start();
    step(200);
    check("lap_pre", 32'(a_time), 'h000050);
    pulse_lap();
    step(120);
    check("lap_live", 32'(a_time), 'h000080);
    pulse_start();
    check("lap_paused_time", 32'(a_time), 'h000080);
    wait_digit(4'h7);
    check("lap_d3", 32'(a_seg), 'h00);
    wait_digit(4'hB);
    check("lap_d2", 32'(a_seg), 'hBF);
    wait_digit(4'hD);
    check("lap_d1", 32'(a_seg), 'h6D);
    wait_digit(4'hE);
    check("lap_d0", 32'(a_seg), 'h3F);
    pulse_lap();
    wait_digit(4'hD);
    check("live_d1", 32'(a_seg), 'h7F);
    wait_digit(4'hB);
    check("live_d2", 32'(a_seg), 'hBF);

    // Reset mid-count
    io_view = 1'b0;
    pulse_start();
    step(10);
    reset = 1'b1;
    step(1);
    check("midrst_time", 32'(a_time), 'h0);
    check("midrst_running", 32'(a_running), 'h0);
    check("midrst_bit", 32'(a_bit), 'hE);
    check("midrst_b_time", 32'(b_time), 'h0);
    reset = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
